instruction_fetch_mem: RTL and testbench

//  Parametrised, synchronous-read successor to the combinational instruction store. Serves the
//  IF stage: registers the fetched word with a valid flag and supports stall, flush and halt

---
 rtl/instruction_fetch_mem.sv | 57 +++++
 tb/tb_instruction_fetch_mem.sv | 139 +++++++++++++
 2 files changed

// File: rtl/instruction_fetch_mem.sv
// instruction_fetch_mem: synchronous-read instruction store feeding the IF stage, with stall, flush, halt and a program-load port
module instruction_fetch_mem #(
  parameter int DATA_W = 32,
  parameter int DEPTH = 2048,
  parameter int ADDR_W = 32,
  parameter int BYTE_ADDR = 0,
  parameter logic [DATA_W-1:0] HALT_WORD = 32'hFFFFFFFF,
  parameter logic [DATA_W-1:0] NOP_WORD = 32'h00000000,
  localparam int AW = $clog2(DEPTH)
) (
  input logic clk,
  input logic reset_n,
  input logic fetch_req,
  input logic [ADDR_W-1:0] fetch_pc,
  input logic stall,
  input logic flush,
  output logic [DATA_W-1:0] instr_out,
  output logic instr_valid,
  output logic addr_err,
  output logic halted,
  input logic prog_we,
  input logic [AW-1:0] prog_addr,
  input logic [DATA_W-1:0] prog_data
);
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);
  logic [DATA_W-1:0] mem [DEPTH] = '{default: NOP_WORD};
  logic [ADDR_W-1:0] idx;
  logic bad;
  logic [DATA_W-1:0] word;
  assign idx = BYTE_ADDR != 0 ? {2'b00, fetch_pc[ADDR_W-1:2]} : fetch_pc;
  assign bad = ({1'b0, idx} >= DEPTH_X) || ((BYTE_ADDR != 0) && (fetch_pc[1:0] != 2'b00));
  assign word = mem[idx[AW-1:0]];
  // program-load write; the fetch register samples mem before this lands, so reads are read-first
  always_ff @(posedge clk)
    if (reset_n && prog_we && (32'(prog_addr) < DEPTH)) mem[prog_addr] <= prog_data;
  // IF/ID output register with priority reset > flush > stall > fetch > idle
  always_ff @(posedge clk)
    if (!reset_n) begin
      instr_out <= NOP_WORD;
      instr_valid <= 1'b0;
      addr_err <= 1'b0;
      halted <= 1'b0;
    end else if (flush) begin
      instr_out <= NOP_WORD;
      instr_valid <= 1'b0;
      addr_err <= 1'b0;
    end else if (stall) begin
    end else if (fetch_req && !halted) begin
      instr_out <= bad ? NOP_WORD : word;
      instr_valid <= 1'b1;
      addr_err <= bad;
      halted <= !bad && (word == HALT_WORD);
    end else begin
      instr_valid <= 1'b0;
      addr_err <= 1'b0;
    end
endmodule

// File: tb/tb_instruction_fetch_mem.sv
// tb_instruction_fetch_mem: scoreboard bench for word- and byte-addressed instances against a behavioural model
module tb_instruction_fetch_mem;
  typedef struct packed {logic [31:0] o; logic v; logic e; logic h;} st_t;
  logic clk = 1'b0;
  logic reset_n, fetch_req, stall, flush, prog_we;
  logic [31:0] fetch_pc, prog_data;
  logic [10:0] prog_addr;
  logic [31:0] out_w, out_b;
  logic v_w, e_w, h_w, v_b, e_b, h_b;
  logic [31:0] mm [2048];
  st_t sw, sb;
  st_t qw[$], qb[$];
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  instruction_fetch_mem #(.BYTE_ADDR(0)) dut (
    .clk(clk), .reset_n(reset_n), .fetch_req(fetch_req), .fetch_pc(fetch_pc), .stall(stall),
    .flush(flush), .instr_out(out_w), .instr_valid(v_w), .addr_err(e_w), .halted(h_w),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data));
  instruction_fetch_mem #(.BYTE_ADDR(1)) dutb (
    .clk(clk), .reset_n(reset_n), .fetch_req(fetch_req), .fetch_pc(fetch_pc), .stall(stall),
    .flush(flush), .instr_out(out_b), .instr_valid(v_b), .addr_err(e_b), .halted(h_b),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data));
  function automatic st_t step(st_t s, bit ba, bit rn, bit fr, logic [31:0] pc, bit st, bit fl);
    longint unsigned wi;
    st_t r = s;
    if (!rn) return '{o: 32'h0, v: 1'b0, e: 1'b0, h: 1'b0};
    if (fl) begin
      r.o = 32'h0; r.v = 1'b0; r.e = 1'b0;
      return r;
    end
    if (st) return r;
    if (!fr || s.h) begin
      r.v = 1'b0; r.e = 1'b0;
      return r;
    end
    wi = ba ? longint'(pc) / 4 : longint'(pc);
    r.v = 1'b1;
    if (wi >= 2048 || (ba && pc % 4 != 0)) begin
      r.o = 32'h0; r.e = 1'b1;
    end else begin
      r.o = mm[wi]; r.e = 1'b0; r.h = (mm[wi] == 32'hFFFFFFFF);
    end
    return r;
  endfunction
  task automatic drive(bit rn, bit fr, logic [31:0] pc, bit st, bit fl, bit we, logic [10:0] pa, logic [31:0] pd);
    reset_n = rn; fetch_req = fr; fetch_pc = pc; stall = st; flush = fl;
    prog_we = we; prog_addr = pa; prog_data = pd;
    sw = step(sw, 1'b0, rn, fr, pc, st, fl);
    sb = step(sb, 1'b1, rn, fr, pc, st, fl);
    if (rn && we) mm[pa] = pd;
    qw.push_back(sw);
    qb.push_back(sb);
    @(posedge clk);
    #1;
  endtask
  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got=%h expected=%h at %0t", n, a, e, $time);
    end
  endtask
  task automatic fetch(logic [31:0] pc);
    drive(1, 1, pc, 0, 0, 0, 0, 0);
  endtask
  task automatic idle();
    drive(1, 0, 0, 0, 0, 0, 0, 0);
  endtask
  initial begin
    st_t ew, eb;
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (qw.size() != 0 && qb.size() != 0) begin
        ew = qw.pop_front();
        eb = qb.pop_front();
        chk("word.instr_out", out_w, ew.o);
        chk("word.instr_valid", 32'(v_w), 32'(ew.v));
        chk("word.addr_err", 32'(e_w), 32'(ew.e));
        chk("word.halted", 32'(h_w), 32'(ew.h));
        chk("byte.instr_out", out_b, eb.o);
        chk("byte.instr_valid", 32'(v_b), 32'(eb.v));
        chk("byte.addr_err", 32'(e_b), 32'(eb.e));
        chk("byte.halted", 32'(h_b), 32'(eb.h));
      end
    end
  end
  initial begin
    for (int i = 0; i < 2048; i++) mm[i] = 32'h0;
    sw = '0;
    sb = '0;
    repeat (3) drive(0, 0, 0, 0, 0, 1, 11'd7, 32'h12345678);
    idle();
    for (int i = 0; i < 4; i++) drive(1, 0, 0, 0, 0, 1, 11'(i), 32'h11111111 * (i + 1));
    for (int i = 0; i < 4; i++) fetch(i);
    idle();
    fetch(1);
    drive(1, 1, 2, 1, 0, 0, 0, 0);
    drive(1, 1, 2, 1, 1, 0, 0, 0);
    idle();
    fetch(8);
    fetch(6);
    fetch(2048);
    idle();
    drive(1, 0, 0, 0, 0, 1, 11'd5, 32'hFFFFFFFF);
    fetch(5);
    fetch(20);
    fetch(0);
    idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    idle();
    fetch(0);
    drive(1, 1, 3, 0, 0, 1, 11'd3, 32'hDEADBEEF);
    fetch(3);
    fetch(12);
    drive(1, 1, 13, 0, 0, 0, 0, 0);
    fetch(32'hFFFFFFFC);
    for (int n = 0; n < 600; n++) begin
      logic [31:0] pc;
      int k;
      k = $urandom_range(0, 3);
      pc = k == 0 ? 32'($urandom_range(0, 20)) : k == 1 ? 32'($urandom_range(0, 63) * 4) :
           k == 2 ? 32'($urandom_range(2040, 2060)) : $urandom;
      drive($urandom_range(0, 39) != 0, $urandom_range(0, 3) != 0, pc,
            $urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 2) == 0,
            11'($urandom_range(0, 15)), $urandom_range(0, 7) == 0 ? 32'hFFFFFFFF : $urandom);
    end
    idle();
    repeat (3) @(negedge clk);
    checks++;
    if (qw.size() != 0 || qb.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", qw.size() + qb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
